// File: rtl/gpu_mat_seq.sv
// gpu_mat_seq
// -----------------------------------------------------------------------------
// Command sequencer that sits in front of gpu_core's command port. Whole-matrix
// multiply ops (dst = mul x src) are queued in a small FIFO and each op is
// expanded into four column slots, one per non-cyc cycle. A column slot drives
// com_we only when its mask bit is set. The sequencer never writes while the
// data port owns the core (cyc high); the column is held instead.
//
// Handshake: an op is transferred on every rising edge where
// op_valid && op_ready. op_ready depends only on FIFO occupancy, never on
// op_valid. The upstream side may change op_* freely while op_valid is low.
//
// Optional feature macro: GPU_SEQ_ALIAS_CHECK_EN
//   When defined, an op popped with dst==mul is dropped. It takes one ISSUE
//   cycle with no com_we, err pulses in the following cycle, and no done is
//   given. When undefined, err is tied low and such ops issue unchanged.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   op_valid/op_ready : op input handshake (op_ready = FIFO not full)
//   op_dst/src/mul    : matrix indices of the op
//   op_col_mask       : bit c set -> column c is written
//   cyc               : data port owns the core this cycle
//   command, com_we   : to gpu_core.command / gpu_core.com_we
//   busy              : FIFO non-empty or an op in flight
//   done, err         : one-cycle pulses per completed / rejected op
//   level             : FIFO occupancy
//   state_dbg         : 1 while the FSM is in ISSUE (observation only)
// -----------------------------------------------------------------------------
module gpu_mat_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAT_COUNT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [1:0]                    op_dst,
  input  logic [1:0]                    op_src,
  input  logic [1:0]                    op_mul,
  input  logic [3:0]                    op_col_mask,
  input  logic                          cyc,
  output logic [15:0]                   command,
  output logic                          com_we,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // The command word has exactly two bits per matrix index.
  if ($clog2(MAT_COUNT) != 2) begin : g_bad_mat_count
    $error("gpu_mat_seq: MAT_COUNT must give a 2-bit matrix index");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("gpu_mat_seq: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Op FIFO: entries {mask, mul, dst, src}; pointers carry an extra wrap bit so
  // full and empty are distinguishable without a separate counter.
  // ---------------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [LW-1:0] wptr_q, rptr_q;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic [9:0]    head;

  assign level      = wptr_q - rptr_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign op_ready   = !fifo_full;
  assign push       = op_valid && !fifo_full;
  assign head       = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= {op_col_mask, op_mul, op_dst, op_src};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + LW'(1);
      if (pop)  rptr_q <= rptr_q + LW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [3:0] mask_q;
  logic [1:0] mul_q, dst_q, src_q;
  logic       drop;    // current op is being rejected this cycle
  logic       finish;  // current op leaves ISSUE at the next edge
  logic       done_q, err_q;

`ifdef GPU_SEQ_ALIAS_CHECK_EN
  // A rejected op does not need any core cycles, so cyc is irrelevant here.
  assign drop = (state_q == S_ISSUE) && (dst_q == mul_q);
`else
  assign drop = 1'b0;
`endif

  assign finish = (state_q == S_ISSUE) && (drop || (!cyc && col_q == 2'd3));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          col_d   = 2'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (finish) begin
          // Chain straight into the next op so back-to-back ops have no gap.
          col_d = 2'd0;
          if (!fifo_empty) pop = 1'b1;
          else             state_d = S_IDLE;
        end else if (!cyc) begin
          col_d = col_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= 2'd0;
      mask_q  <= 4'd0;
      mul_q   <= 2'd0;
      dst_q   <= 2'd0;
      src_q   <= 2'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (pop) begin
        mask_q <= head[9:6];
        mul_q  <= head[5:4];
        dst_q  <= head[3:2];
        src_q  <= head[1:0];
      end
      done_q <= finish && !drop;
      err_q  <= drop;
    end
  end

  assign com_we    = (state_q == S_ISSUE) && !cyc && mask_q[col_q] && !drop;
  assign command   = (state_q == S_ISSUE) ? {8'b0, mul_q, dst_q, src_q, col_q} : 16'h0000;
  assign busy      = !fifo_empty || (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = (state_q == S_ISSUE);

endmodule

// File: tb/tb_gpu_mat_seq.sv
// Testbench for gpu_mat_seq. Inputs are driven 1 time unit after each rising
// edge; outputs are sampled on the falling edge. Accepted ops push their
// expected column commands into exp_q and an expected outcome (done or err)
// into outc_q; the monitor pops and compares whenever the DUT shows com_we,
// done or err.
module tb_gpu_mat_seq;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_dst, op_src, op_mul;
  logic [3:0]  op_col_mask;
  logic        cyc;
  logic [15:0] command;
  logic        com_we, busy, done, err;
  logic [2:0]  level;
  logic        state_dbg;

  gpu_mat_seq #(.FIFO_DEPTH(4), .MAT_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_dst(op_dst), .op_src(op_src), .op_mul(op_mul), .op_col_mask(op_col_mask),
    .cyc(cyc), .command(command), .com_we(com_we), .busy(busy), .done(done),
    .err(err), .level(level), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  int          exp_n_q[$];   // expected com_we count per op
  bit          outc_q[$];    // 0 = done expected, 1 = err expected
  int          cur_n = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An op writes column c of dst with mul x src whenever mask bit c is set.
  task automatic sb_push(input logic [3:0] m, input logic [1:0] mul,
                         input logic [1:0] dst, input logic [1:0] src);
    int n = 0;
    bit rej = 0;
`ifdef GPU_SEQ_ALIAS_CHECK_EN
    rej = (dst == mul);
`endif
    if (!rej)
      for (int c = 0; c < 4; c++)
        if (m[c]) begin
          exp_q.push_back(16'(int'(mul) * 64 + int'(dst) * 16 + int'(src) * 4 + c));
          n++;
        end
    exp_n_q.push_back(n);
    outc_q.push_back(rej);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_n_q.delete();
      outc_q.delete();
      cur_n = 0;
    end else begin
      // An op's completion pulse coincides with the next op's col 0, so the
      // outcome is settled before this cycle's command is counted.
      if (done || err) begin
        if (outc_q.size() == 0) begin
          check("unexpected_done_err", 1, 0);
        end else begin
          bit o;
          int n;
          o = outc_q.pop_front();
          n = exp_n_q.pop_front();
          check("outcome_is_err", int'(err), int'(o));
          check("writes_per_op", cur_n, n);
        end
        cur_n = 0;
      end
      if (com_we) begin
        if (exp_q.size() == 0) check("unexpected_com_we", 1, 0);
        else                   check("command", int'(command), int'(exp_q.pop_front()));
        cur_n++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic push_op(input logic [3:0] m, input logic [1:0] mul,
                         input logic [1:0] dst, input logic [1:0] src);
    int w = 0;
    while (!op_ready && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!op_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      op_valid = 1'b1; op_col_mask = m; op_mul = mul; op_dst = dst; op_src = src;
      sb_push(m, mul, dst, src);
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
  endtask

  // Counts cycles and com_we strobes after an accept until done or err.
  task automatic run_op(output int cycles, output int we_cnt, output int first_we,
                        output bit got_done, output bit got_err, output bit busy_end);
    cycles = 0; we_cnt = 0; first_we = -1;
    got_done = 0; got_err = 0; busy_end = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done || err) begin
        got_done = done; got_err = err; busy_end = busy;
        break;
      end
      if (com_we) begin
        if (first_we < 0) first_we = cycles;
        we_cnt++;
      end
      cycles++;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_op_ready"}, int'(op_ready), 1);
    check({tag, "_command"},  int'(command), 0);
    check({tag, "_com_we"},   int'(com_we), 0);
    check({tag, "_busy"},     int'(busy), 0);
    check({tag, "_done"},     int'(done), 0);
    check({tag, "_err"},      int'(err), 0);
    check({tag, "_level"},    int'(level), 0);
  endtask

  bit rnd_run;

  // ---------------- main sequence ----------------
  initial begin
    int cy, we, fw, t, first, last, cnt, dn;
    bit gd, ge, be;
    logic [1:0] mm, dd;

    rst_n = 1'b0; op_valid = 1'b0; op_col_mask = '0; op_mul = '0; op_dst = '0;
    op_src = '0; cyc = 1'b0;
    #3;
    check_reset_values("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Uncontended full-mask op: commands 0x60..0x63.
    push_op(4'hF, 2'd1, 2'd2, 2'd0);
    run_op(cy, we, fw, gd, ge, be);
    check("t1_cycles", cy, 5);
    check("t1_writes", we, 4);
    check("t1_first_we", fw, 1);
    check("t1_done", int'(gd), 1);
    check("t1_busy_at_done", int'(be), 0);

    // Three cyc cycles during col 1.
    push_op(4'hF, 2'd1, 2'd2, 2'd0);
    fork
      run_op(cy, we, fw, gd, ge, be);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        cyc = 1'b0;
      end
    join
    check("t2_cycles", cy, 8);
    check("t2_writes", we, 4);
    check("t2_done", int'(gd), 1);

    // Sparse mask: only cols 0 and 2 are written, op still walks 4 columns.
    push_op(4'b0101, 2'd1, 2'd2, 2'd0);
    run_op(cy, we, fw, gd, ge, be);
    check("t3_cycles", cy, 5);
    check("t3_writes", we, 2);
    check("t3_done", int'(gd), 1);

    // Empty mask.
    push_op(4'b0000, 2'd2, 2'd0, 2'd1);
    run_op(cy, we, fw, gd, ge, be);
    check("t3b_cycles", cy, 5);
    check("t3b_writes", we, 0);
    check("t3b_done", int'(gd), 1);

    // Five back-to-back full-mask ops: FIFO fills, 20 gapless writes.
    first = -1; last = -1; cnt = 0; dn = 0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          mm = 2'($urandom_range(0, 3));
          dd = mm ^ 2'($urandom_range(1, 3));
          push_op(4'hF, mm, dd, 2'($urandom_range(0, 3)));
        end
        check("t4_level_full", int'(level), 4);
        check("t4_op_ready_low", int'(op_ready), 0);
      end
      begin
        t = 0;
        while (dn < 5 && t < 300) begin
          @(negedge clk);
          if (com_we) begin
            if (first < 0) first = t;
            last = t;
            cnt++;
          end
          if (done) dn++;
          t++;
        end
        @(posedge clk); #1;
      end
    join
    check("t4_writes", cnt, 20);
    check("t4_write_span", last - first + 1, 20);
    check("t4_dones", dn, 5);

    // Aliased dst==mul.
    push_op(4'hF, 2'd3, 2'd3, 2'd1);
    run_op(cy, we, fw, gd, ge, be);
`ifdef GPU_SEQ_ALIAS_CHECK_EN
    check("t5_writes", we, 0);
    check("t5_err", int'(ge), 1);
    check("t5_done", int'(gd), 0);
`else
    check("t5_writes", we, 4);
    check("t5_err", int'(ge), 0);
    check("t5_done", int'(gd), 1);
`endif

    // Randomized ops with random cyc contention.
    rnd_run = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          push_op(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        t = 0;
        while (busy && t < 2000) begin @(posedge clk); #1; t++; end
        check("rnd_drained", int'(busy), 0);
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          cyc = ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
        end
        cyc = 1'b0;
      end
    join
    @(posedge clk); #1;

    // Reset during col 2, then a fresh op from col 0.
    push_op(4'hF, 2'd1, 2'd2, 2'd3);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_op(4'hF, 2'd2, 2'd1, 2'd3);
    run_op(cy, we, fw, gd, ge, be);
    check("t6_cycles", cy, 5);
    check("t6_writes", we, 4);
    check("t6_done", int'(gd), 1);

    repeat (2) begin @(posedge clk); #1; end
    check("final_cmds_left", exp_q.size(), 0);
    check("final_outcomes_left", outc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gpu_mat_seq.md
# gpu_mat_seq

Command sequencer directly upstream of `gpu_core`'s command port. It accepts whole-matrix multiply operations (`dst = mul × src`) into a small FIFO. It expands each operation into up to four column commands (`command`/`com_we`), one per cycle, and yields to the data port whenever `cyc` is high. Its outputs connect straight to `gpu_core.command`, `gpu_core.com_we`, and observe the same `cyc` that drives `gpu_core`.

## Interface
- `FIFO_DEPTH`, default 4: op FIFO entries; power of two, ≥2.
- `MAT_COUNT`, default 4: matrices in core. Index width is `$clog2(MAT_COUNT)`; the command encoding fixes it at 2 bits.

Ports:
- `clk` — in, 1: single clock; all state on rising edge.
- `rst_n` — in, 1: asynchronous, active-low reset.
- `op_valid` — in, 1: op offered.
- `op_ready` — out, 1: FIFO not full; op accepted on edge where `op_valid && op_ready`.
- `op_dst` — in, 2: destination matrix.
- `op_src` — in, 2: source matrix (columns read).
- `op_mul` — in, 2: multiplier matrix.
- `op_col_mask` — in, 4: bit c set → column c written.
- `cyc` — in, 1: data port owns core this cycle; sequencer must not assert `com_we`.
- `command` — out, 16: `{8'b0, mul[1:0], dst[1:0], src[1:0], col[1:0]}`.
- `com_we` — out, 1: command write strobe to core.
- `busy` — out, 1: FIFO non-empty or state ≠ IDLE.
- `done` — out, 1: one-cycle pulse per completed op.
- `err` — out, 1: one-cycle pulse per rejected op (only with macro, see Configuration).
- `level` — out, `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.

## Operation
- FIFO: 10-bit entries `{mask, mul, dst, src}`, circular read/write pointers with wrap bit. `op_ready = !full`. Push and pop on the same edge are both honoured; no bypass, so an op pushed into an empty FIFO is visible one edge later.
- FSM states IDLE, ISSUE.
  - IDLE: if FIFO non-empty, pop into op register, `col←0`, go ISSUE. Else stay.
  - ISSUE: `com_we = !cyc && mask[col]`.
    - If `cyc`: hold `col` (stall).
    - Else advance `col`. Unmasked columns still take one non-`cyc` cycle.
    - On advancing past col 3: pulse `done` next cycle. If FIFO non-empty, pop next op and stay ISSUE with `col←0`; else go IDLE.
- `command` is driven from op register and `col` in ISSUE and is 16'h0000 in IDLE.
- Mask 4'b0000: op walks 4 cycles, no `com_we`, `done` pulses.
- Aliasing `dst==src` is legal, because each column reads only its own source column. `dst==mul` corrupts later columns; see Configuration.
- Reset mid-op: FIFO emptied and FSM returns to IDLE immediately. Columns already written in core stay written. No `done` is issued.
- Reset values: `op_ready=1`, `command=0`, `com_we=0`, `busy=0`, `done=0`, `err=0`, `level=0`.

## Timing
- Op accepted at edge N; popped at edge N+1. Column 0 `com_we` is high in cycle N+1→N+2 (if `!cyc`), and the core write happens at edge N+2.
- Uncontended op: 4 cycles in ISSUE. `done` is high in the cycle after the col-3 edge.
- Back-to-back ops: zero idle cycles between ops. The `done` of op k coincides with col 0 of op k+1.
- Each `cyc` cycle adds exactly one stall cycle. `com_we` is combinational from state, mask, and `cyc`. No other output depends combinationally on inputs.

## Configuration
- `GPU_SEQ_ALIAS_CHECK_EN` defined:
  - An op popped with `dst==mul` is dropped: no `com_we`, `err` pulses in the following cycle, no `done`.
  - The FSM proceeds as if the op completed: pop next op or go IDLE.
- Undefined: `err` is tied 0 and such ops are issued unchanged.

## Test plan
- Reset then push `{mask=F, mul=1, dst=2, src=0}`, `cyc=0` → `command` = 0x0060, 0x0061, 0x0062, 0x0063 with `com_we` on 4 consecutive cycles starting 1 cycle after accept. `done` one cycle after; `busy` drops with `done`.
- Same op with `cyc` high for 3 cycles during col 1 → `command` holds 0x0061, `com_we` low for those 3 cycles, total 7 ISSUE cycles, no column skipped.
- Mask 4'b0101 → `com_we` only for cols 0 and 2 (0x0060, 0x0062), `done` still after 4 cycles.
- Push 5 ops with `FIFO_DEPTH=4` while sequencer busy → `op_ready` low at `level=4`. All 20 column commands issue with no gaps; 5 `done` pulses.
- With `GPU_SEQ_ALIAS_CHECK_EN`, push `{mul=3, dst=3}` → no `com_we`, one `err` pulse, no `done`. Without the macro → 4 writes issued, `err` stays 0.
- Assert `rst_n=0` during col 2 → all outputs at reset values asynchronously, `level=0`. After release, a new op issues normally from col 0.
